// File: rtl/lsu_dmem_master_pkg.sv
// Shared encodings for the LSU data-memory master.
// funct3 codes, dmem write types, FSM states and decode helpers.
package lsu_dmem_master_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  localparam logic [2:0] RD_WORD = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD0,
    S_LD1,
    S_ST,
    S_RESP
  } state_t;

  function automatic logic f3_legal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return f3 == F3_SB || f3 == F3_SH ||
             f3 == F3_SW;
    return f3 == F3_LB || f3 == F3_LH ||
           f3 == F3_LW || f3 == F3_LBU ||
           f3 == F3_LHU;
  endfunction

  function automatic logic is_misaligned(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    return (sz == 2'b01 && off[0]) ||
           (sz == 2'b10 && off != 2'b00);
  endfunction

  function automatic logic [1:0] wr_type_of(
    input logic [2:0] f3
  );
    case (f3)
      F3_SB:   return WR_SB;
      F3_SH:   return WR_SH;
      default: return WR_SW;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    case (f3)
      F3_SB:   return {4{d[7:0]}};
      F3_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dmem_master_if.sv
// Request/response channel and dmem port bundles.
// master drives the request side of each link.
interface lsu_req_if #(
  parameter int TAG_W = 5
);
  logic             i_req_valid;
  logic             o_req_ready;
  logic             i_req_we;
  logic [2:0]       i_req_funct3;
  logic [31:0]      i_req_addr;
  logic [31:0]      i_req_wdata;
  logic [TAG_W-1:0] i_req_tag;
  logic             o_rsp_valid;
  logic [31:0]      o_rsp_rdata;
  logic [TAG_W-1:0] o_rsp_tag;
  logic             o_rsp_err;

  modport master (
    output i_req_valid, i_req_we,
    output i_req_funct3, i_req_addr,
    output i_req_wdata, i_req_tag,
    input  o_req_ready, o_rsp_valid,
    input  o_rsp_rdata, o_rsp_tag,
    input  o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_we,
    input  i_req_funct3, i_req_addr,
    input  i_req_wdata, i_req_tag,
    output o_req_ready, o_rsp_valid,
    output o_rsp_rdata, o_rsp_tag,
    output o_rsp_err
  );
endinterface

interface lsu_dmem_if;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [1:0]  o_dmem_wr_type;
  logic [2:0]  o_dmem_rd_type;
  logic        o_dmem_wr_en;
  logic        o_dmem_rd_en;
  logic [31:0] i_dmem_rdata;

  modport master (
    output o_dmem_addr, o_dmem_wdata,
    output o_dmem_wr_type, o_dmem_rd_type,
    output o_dmem_wr_en, o_dmem_rd_en,
    input  i_dmem_rdata
  );

  modport slave (
    input  o_dmem_addr, o_dmem_wdata,
    input  o_dmem_wr_type, o_dmem_rd_type,
    input  o_dmem_wr_en, o_dmem_rd_en,
    output i_dmem_rdata
  );
endinterface

// File: rtl/lsu_dmem_master_load_align.sv
// Load lane select and sign/zero extension.
// Only the low three bytes of w1 can reach the result.
module lsu_load_align
  import lsu_dmem_master_pkg::*;
(
  input  logic [23:0] i_w1,
  input  logic [31:0] i_w0,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [31:0] w_sh;

  // shift {w1,w0} right by whole bytes
  always_comb begin
    w_sh = i_w0;
    unique case (i_off)
      2'd0: w_sh = i_w0;
      2'd1: w_sh = {i_w1[7:0], i_w0[31:8]};
      2'd2: w_sh = {i_w1[15:0], i_w0[31:16]};
      2'd3: w_sh = {i_w1[23:0], i_w0[31:24]};
      default: w_sh = i_w0;
    endcase
  end

  // extend to 32 bits per load kind
  always_comb begin
    o_data = '0;
    unique case (i_funct3)
      F3_LB:  o_data = {{24{w_sh[7]}}, w_sh[7:0]};
      F3_LH:  o_data = {{16{w_sh[15]}}, w_sh[15:0]};
      F3_LW:  o_data = w_sh;
      F3_LBU: o_data = {24'h0, w_sh[7:0]};
      F3_LHU: o_data = {16'h0, w_sh[15:0]};
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// LSU sequencer driving the data-memory port.
// Misaligned accesses become word reads or byte writes.
module lsu_dmem_master
  import lsu_dmem_master_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1,
  parameter int TAG_W = 5
) (
  input logic        clk,
  input logic        rst,
  lsu_req_if.slave   req,
  lsu_dmem_if.master dmem
);

  state_t           r_state, w_state;
  logic [2:0]       r_f3, w_f3;
  logic [31:0]      r_addr, w_addr;
  logic [31:0]      r_wdata, w_wdata;
  logic [TAG_W-1:0] r_tag, w_tag;
  logic [31:0]      r_w0, w_w0;
  logic [1:0]       r_cnt, w_cnt;
  logic [1:0]       r_last, w_last;
  logic             r_mis, w_mis;

  logic [31:0]      r_d_addr, w_d_addr;
  logic [31:0]      r_d_wdata, w_d_wdata;
  logic [1:0]       r_d_wtype, w_d_wtype;
  logic             r_d_wen, w_d_wen;
  logic             r_d_ren, w_d_ren;
  logic             r_rsp_v, w_rsp_v;
  logic [31:0]      r_rsp_d, w_rsp_d;
  logic [TAG_W-1:0] r_rsp_t, w_rsp_t;
  logic             r_rsp_e, w_rsp_e;

  logic             w_req_mis;
  logic             w_req_err;
  logic [1:0]       w_cnt_inc;
  logic [31:0]      w_st_shift;
  logic [23:0]      w_al_w1;
  logic [31:0]      w_al_w0;
  logic [31:0]      w_al_data;

  assign w_req_mis = is_misaligned(
    req.i_req_funct3[1:0], req.i_req_addr[1:0]);
  assign w_req_err =
    !f3_legal(req.i_req_we, req.i_req_funct3) ||
    (w_req_mis && !SPLIT_MISALIGNED);
  assign w_cnt_inc = r_cnt + 2'd1;
  assign w_st_shift = r_wdata >> {w_cnt_inc, 3'b000};

  assign w_al_w1 = (r_state == S_LD1) ?
    dmem.i_dmem_rdata[23:0] : 24'h0;
  assign w_al_w0 = (r_state == S_LD1) ?
    r_w0 : dmem.i_dmem_rdata;

  lsu_load_align u_align (
    .i_w1     (w_al_w1),
    .i_w0     (w_al_w0),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_f3),
    .o_data   (w_al_data)
  );

  // next state and next registered outputs
  always_comb begin
    w_state   = r_state;
    w_f3      = r_f3;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_tag     = r_tag;
    w_w0      = r_w0;
    w_cnt     = r_cnt;
    w_last    = r_last;
    w_mis     = r_mis;
    w_d_addr  = '0;
    w_d_wdata = '0;
    w_d_wtype = WR_NONE;
    w_d_wen   = 1'b0;
    w_d_ren   = 1'b0;
    w_rsp_v   = 1'b0;
    w_rsp_d   = '0;
    w_rsp_t   = '0;
    w_rsp_e   = 1'b0;
    unique case (r_state)
      S_IDLE: if (req.i_req_valid) begin
        w_f3    = req.i_req_funct3;
        w_addr  = req.i_req_addr;
        w_wdata = req.i_req_wdata;
        w_tag   = req.i_req_tag;
        w_mis   = w_req_mis;
        w_cnt   = 2'd0;
        w_last  = req.i_req_funct3[1] ?
          2'd3 : 2'd1;
        if (w_req_err) begin
          w_state = S_RESP;
          w_rsp_v = 1'b1;
          w_rsp_e = 1'b1;
          w_rsp_t = req.i_req_tag;
        end else if (!req.i_req_we) begin
          w_state  = S_LD0;
          w_d_ren  = 1'b1;
          w_d_addr = req.i_req_addr & ~32'h3;
        end else begin
          w_state  = S_ST;
          w_d_wen  = 1'b1;
          w_d_addr = req.i_req_addr;
          if (w_req_mis) begin
            w_d_wtype = WR_SB;
            w_d_wdata = {4{req.i_req_wdata[7:0]}};
          end else begin
            w_d_wtype = wr_type_of(req.i_req_funct3);
            w_d_wdata = lane_data(req.i_req_funct3,
                                  req.i_req_wdata);
          end
        end
      end
      S_LD0: begin
        w_w0 = dmem.i_dmem_rdata;
        if (r_mis) begin
          w_state  = S_LD1;
          w_d_ren  = 1'b1;
          w_d_addr = (r_addr & ~32'h3) + 32'd4;
        end else begin
          w_state = S_RESP;
          w_rsp_v = 1'b1;
          w_rsp_d = w_al_data;
          w_rsp_t = r_tag;
        end
      end
      S_LD1: begin
        w_state = S_RESP;
        w_rsp_v = 1'b1;
        w_rsp_d = w_al_data;
        w_rsp_t = r_tag;
      end
      S_ST: begin
        if (r_mis && r_cnt != r_last) begin
          w_cnt     = w_cnt_inc;
          w_d_wen   = 1'b1;
          w_d_wtype = WR_SB;
          w_d_addr  = r_addr + {30'h0, w_cnt_inc};
          w_d_wdata = {4{w_st_shift[7:0]}};
        end else begin
          w_state = S_RESP;
          w_rsp_v = 1'b1;
          w_rsp_t = r_tag;
        end
      end
      S_RESP: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  // state, captured request and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tag     <= '0;
      r_w0      <= '0;
      r_cnt     <= '0;
      r_last    <= '0;
      r_mis     <= 1'b0;
      r_d_addr  <= '0;
      r_d_wdata <= '0;
      r_d_wtype <= WR_NONE;
      r_d_wen   <= 1'b0;
      r_d_ren   <= 1'b0;
      r_rsp_v   <= 1'b0;
      r_rsp_d   <= '0;
      r_rsp_t   <= '0;
      r_rsp_e   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_f3      <= w_f3;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_tag     <= w_tag;
      r_w0      <= w_w0;
      r_cnt     <= w_cnt;
      r_last    <= w_last;
      r_mis     <= w_mis;
      r_d_addr  <= w_d_addr;
      r_d_wdata <= w_d_wdata;
      r_d_wtype <= w_d_wtype;
      r_d_wen   <= w_d_wen;
      r_d_ren   <= w_d_ren;
      r_rsp_v   <= w_rsp_v;
      r_rsp_d   <= w_rsp_d;
      r_rsp_t   <= w_rsp_t;
      r_rsp_e   <= w_rsp_e;
    end
  end

  assign req.o_req_ready     = (r_state == S_IDLE);
  assign req.o_rsp_valid     = r_rsp_v;
  assign req.o_rsp_rdata     = r_rsp_d;
  assign req.o_rsp_tag       = r_rsp_t;
  assign req.o_rsp_err       = r_rsp_e;
  assign dmem.o_dmem_addr    = r_d_addr;
  assign dmem.o_dmem_wdata   = r_d_wdata;
  assign dmem.o_dmem_wr_type = r_d_wtype;
  assign dmem.o_dmem_rd_type = RD_WORD;
  assign dmem.o_dmem_wr_en   = r_d_wen;
  assign dmem.o_dmem_rd_en   = r_d_ren;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Bench for lsu_dmem_master: vector table, hand sequences,
// random traffic against a byte-level memory model.
module tb_lsu_dmem_master;
  import lsu_dmem_master_pkg::*;

  localparam int TW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_req_if #(.TAG_W(TW)) rq ();
  lsu_dmem_if dm ();
  lsu_req_if #(.TAG_W(TW)) rq0 ();
  lsu_dmem_if dm0 ();

  lsu_dmem_master #(.SPLIT_MISALIGNED(1'b1), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .req(rq), .dmem(dm));
  lsu_dmem_master #(.SPLIT_MISALIGNED(1'b0), .TAG_W(TW)) dut0 (
    .clk(clk), .rst(rst), .req(rq0), .dmem(dm0));

  bit [7:0] mem [bit [31:0]];
  bit [7:0] rmem [bit [31:0]];

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] q_ra[$];
  logic [31:0] q_wa[$];
  logic [31:0] q_wd[$];
  logic [1:0]  q_wt[$];
  logic [31:0] g_rdata;
  logic        g_err;
  int          g_lat;

  function automatic bit [7:0] mb(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  function automatic bit [7:0] rb(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] rdw(input logic [31:0] a);
    logic [31:0] b;
    b = a & ~32'h3;
    return {mb(b + 32'd3), mb(b + 32'd2), mb(b + 32'd1), mb(b)};
  endfunction

  // byte-lane memory; it shares the core reset, so no write under rst
  always @(posedge clk) begin
    if (dm.o_dmem_wr_en && !rst) begin
      logic [31:0] a;
      int n;
      a = dm.o_dmem_addr;
      n = (dm.o_dmem_wr_type == WR_SB) ? 1 :
          (dm.o_dmem_wr_type == WR_SH) ? 2 : 4;
      if (n == 2) a[0] = 1'b0;
      if (n == 4) a[1:0] = 2'b00;
      for (int i = 0; i < n; i++) begin
        logic [31:0] ai;
        ai = a + 32'(i);
        mem[ai] = dm.o_dmem_wdata[8*ai[1:0] +: 8];
      end
    end
    #1;
    dm.i_dmem_rdata = rdw(dm.o_dmem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pokeb(input logic [31:0] a, input logic [7:0] b);
    mem[a] = b;
    rmem[a] = b;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) pokeb(a + 32'(i), w[8*i +: 8]);
  endtask

  // reference: RISC-V load/store semantics over a byte array
  function automatic void model(
    input logic we, input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] d, input bit split,
    output logic [31:0] er, output logic ee,
    output int lat, output int nrd, output int nwr);
    bit legal, mis;
    int sz;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) :
      (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 ||
       f3 == 3'd4 || f3 == 3'd5);
    sz = 1 << f3[1:0];
    mis = (a & 32'(sz - 1)) != 0;
    er = '0; ee = 1'b0; nrd = 0; nwr = 0; lat = 1;
    if (!legal || (mis && !split)) begin
      ee = 1'b1;
      return;
    end
    if (!we) begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rb(a + 32'(i));
      if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
      er = v;
      lat = mis ? 3 : 2;
      nrd = mis ? 2 : 1;
    end else begin
      for (int i = 0; i < sz; i++) rmem[a + 32'(i)] = d[8*i +: 8];
      lat = mis ? sz + 1 : 2;
      nwr = mis ? sz : 1;
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [TW-1:0] tag, input string nm);
    logic [31:0] er;
    logic ee;
    int el, enr, enw, k;
    bit seen, bad;
    logic [TW-1:0] gt;
    model(we, f3, a, d, 1'b1, er, ee, el, enr, enw);
    q_ra.delete(); q_wa.delete(); q_wd.delete(); q_wt.delete();
    @(negedge clk);
    chk({nm, " ready"}, 32'(rq.o_req_ready), 32'd1);
    rq.i_req_valid = 1'b1;
    rq.i_req_we = we;
    rq.i_req_funct3 = f3;
    rq.i_req_addr = a;
    rq.i_req_wdata = d;
    rq.i_req_tag = tag;
    @(posedge clk);
    #1 rq.i_req_valid = 1'b0;
    seen = 0; bad = 0; k = 0; gt = '0;
    g_rdata = '0; g_err = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (rq.o_req_ready) bad = 1;
      if (dm.o_dmem_rd_en) q_ra.push_back(dm.o_dmem_addr);
      if (dm.o_dmem_wr_en) begin
        q_wa.push_back(dm.o_dmem_addr);
        q_wd.push_back(dm.o_dmem_wdata);
        q_wt.push_back(dm.o_dmem_wr_type);
      end
      if (dm.o_dmem_rd_en && dm.o_dmem_wr_en) bad = 1;
      if (!dm.o_dmem_rd_en && !dm.o_dmem_wr_en &&
          (dm.o_dmem_addr != 0 || dm.o_dmem_wdata != 0 ||
           dm.o_dmem_wr_type != 0)) bad = 1;
      if (dm.o_dmem_rd_type != RD_WORD) bad = 1;
      if (rq.o_rsp_valid) begin
        seen = 1;
        g_rdata = rq.o_rsp_rdata;
        g_err = rq.o_rsp_err;
        gt = rq.o_rsp_tag;
      end else if (rq.o_rsp_rdata != 0 || rq.o_rsp_tag != 0 ||
                   rq.o_rsp_err) bad = 1;
    end
    g_lat = seen ? k : -1;
    chk({nm, " rsp seen"}, 32'(seen), 32'd1);
    chk({nm, " latency"}, 32'(g_lat), 32'(el));
    chk({nm, " rdata"}, g_rdata, er);
    chk({nm, " err"}, 32'(g_err), 32'(ee));
    chk({nm, " tag"}, 32'(gt), 32'(tag));
    chk({nm, " reads"}, 32'(q_ra.size()), 32'(enr));
    chk({nm, " writes"}, 32'(q_wa.size()), 32'(enw));
    chk({nm, " protocol"}, 32'(bad), 32'd0);
  endtask

  task automatic do_req0(input logic [2:0] f3, input logic [31:0] a,
                         input string nm, input logic [31:0] er,
                         input logic ee, input int el, input int enr);
    int k, nr, nw;
    bit seen;
    logic [31:0] gd;
    logic ge;
    @(negedge clk);
    rq0.i_req_valid = 1'b1;
    rq0.i_req_we = 1'b0;
    rq0.i_req_funct3 = f3;
    rq0.i_req_addr = a;
    rq0.i_req_tag = 5'd9;
    @(posedge clk);
    #1 rq0.i_req_valid = 1'b0;
    seen = 0; k = 0; nr = 0; nw = 0; gd = '0; ge = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (dm0.o_dmem_rd_en) nr++;
      if (dm0.o_dmem_wr_en) nw++;
      if (rq0.o_rsp_valid) begin
        seen = 1; gd = rq0.o_rsp_rdata; ge = rq0.o_rsp_err;
      end
    end
    chk({nm, " latency"}, 32'(seen ? k : -1), 32'(el));
    chk({nm, " rdata"}, gd, er);
    chk({nm, " err"}, 32'(ge), 32'(ee));
    chk({nm, " reads"}, 32'(nr), 32'(enr));
    chk({nm, " writes"}, 32'(nw), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [4:0]  tag;
    logic [31:0] er;
    logic        ee;
    int          lat;
  } vec_t;

  vec_t tv[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    int cnt, k;
    bit rs;
    rq.i_req_valid = 0; rq.i_req_we = 0; rq.i_req_funct3 = 0;
    rq.i_req_addr = 0; rq.i_req_wdata = 0; rq.i_req_tag = 0;
    rq0.i_req_valid = 0; rq0.i_req_we = 0; rq0.i_req_funct3 = 0;
    rq0.i_req_addr = 0; rq0.i_req_wdata = 0; rq0.i_req_tag = 0;
    dm.i_dmem_rdata = 0;
    dm0.i_dmem_rdata = 0;

    tv[0] = '{0, 3'b000, 32'h101, 0, 7, 32'hFFFFFFAA, 0, 2};
    tv[1] = '{0, 3'b100, 32'h101, 0, 1, 32'h000000AA, 0, 2};
    tv[2] = '{0, 3'b001, 32'h102, 0, 2, 32'hFFFF8899, 0, 2};
    tv[3] = '{0, 3'b101, 32'h102, 0, 3, 32'h00008899, 0, 2};
    tv[4] = '{0, 3'b010, 32'h100, 0, 4, 32'h8899AABB, 0, 2};
    tv[5] = '{0, 3'b000, 32'h103, 0, 5, 32'hFFFFFF88, 0, 2};
    tv[6] = '{0, 3'b101, 32'h101, 0, 6, 32'h000099AA, 0, 3};
    tv[7] = '{1, 3'b001, 32'h302, 32'h1234, 8, 0, 0, 2};
    tv[8] = '{0, 3'b011, 32'h100, 0, 9, 0, 1, 1};
    tv[9] = '{1, 3'b011, 32'h100, 32'h55, 10, 0, 1, 1};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ready", 32'(rq.o_req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rq.o_rsp_valid), 32'd0);
    chk("reset dmem en", {30'h0, dm.o_dmem_rd_en, dm.o_dmem_wr_en}, 0);
    chk("reset dmem addr", dm.o_dmem_addr, 32'h0);
    rst = 1'b0;

    poke(32'h100, 32'h8899AABB);
    for (int i = 0; i < 10; i++) begin
      do_req(tv[i].we, tv[i].f3, tv[i].a, tv[i].d, tv[i].tag,
             $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table rdata", i), g_rdata, tv[i].er);
      chk($sformatf("vec%0d table err", i), 32'(g_err), 32'(tv[i].ee));
      chk($sformatf("vec%0d table lat", i), 32'(g_lat), 32'(tv[i].lat));
      if (i == 7) begin
        chk("sh addr", q_wa.size() > 0 ? q_wa[0] : 32'hX, 32'h302);
        chk("sh wdata", q_wd.size() > 0 ? q_wd[0] : 32'hX, 32'h12341234);
        chk("sh wr_type", q_wt.size() > 0 ? 32'(q_wt[0]) : 32'hX, 32'd2);
      end
    end

    poke(32'h100, 32'h44332211);
    poke(32'h104, 32'h88776655);
    do_req(0, 3'b010, 32'h102, 0, 5'd11, "lw mis");
    chk("lw mis value", g_rdata, 32'h66554433);
    chk("lw mis rd0", q_ra.size() > 0 ? q_ra[0] : 32'hX, 32'h100);
    chk("lw mis rd1", q_ra.size() > 1 ? q_ra[1] : 32'hX, 32'h104);

    do_req(1, 3'b010, 32'h203, 32'hDEADBEEF, 5'd12, "sw mis");
    chk("sw mis lat", 32'(g_lat), 32'd5);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ew;
      ew = 32'hDEADBEEF >> (8 * i);
      chk($sformatf("sw mis addr%0d", i),
          q_wa.size() > i ? q_wa[i] : 32'hX, 32'h203 + 32'(i));
      chk($sformatf("sw mis byte%0d", i),
          q_wd.size() > i ? {24'h0, q_wd[i][7:0]} : 32'hX,
          {24'h0, ew[7:0]});
    end
    chk("mem 203", 32'(mb(32'h203)), 32'hEF);
    chk("mem 204", {8'h0, mb(32'h206), mb(32'h205), mb(32'h204)},
        32'h00DEADBE);

    poke(32'hFFFFFFFC, 32'hA1B2C3D4);
    poke(32'h0, 32'h01020304);
    do_req(0, 3'b010, 32'hFFFFFFFE, 0, 5'd13, "lw wrap");
    chk("lw wrap value", g_rdata, 32'h0304A1B2);
    chk("lw wrap rd1", q_ra.size() > 1 ? q_ra[1] : 32'hX, 32'h0);

    do_req0(3'b010, 32'h401, "nosplit lw", 32'h0, 1'b1, 1, 0);
    do_req0(3'b011, 32'h400, "nosplit f3", 32'h0, 1'b1, 1, 0);
    do_req0(3'b010, 32'h400, "nosplit ok", 32'h0, 1'b0, 2, 1);

    for (int i = 0; i < 64; i++) begin
      poke(32'h700 + 32'(4 * i), $urandom);
    end
    poke(32'hFFFFFFF8, $urandom);
    poke(32'h4, $urandom);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ?
        32'hFFFFFFF8 + 32'($urandom_range(0, 7)) :
        32'h700 + 32'($urandom_range(0, 47));
      do_req(1'($urandom), 3'($urandom), a, $urandom,
             TW'($urandom), $sformatf("rnd%0d", i));
    end

    pokeb(32'h603, 8'h11); pokeb(32'h604, 8'h22);
    pokeb(32'h605, 8'h33); pokeb(32'h606, 8'h44);
    @(negedge clk);
    rq.i_req_valid = 1'b1; rq.i_req_we = 1'b1;
    rq.i_req_funct3 = 3'b010; rq.i_req_addr = 32'h603;
    rq.i_req_wdata = 32'hCAFEF00D; rq.i_req_tag = 5'd14;
    @(posedge clk);
    #1 rq.i_req_valid = 1'b0;
    cnt = 0; k = 0; rs = 0;
    while (cnt < 3 && k < 10) begin
      @(negedge clk);
      k++;
      if (rq.o_rsp_valid) rs = 1;
      if (dm.o_dmem_wr_en) cnt++;
    end
    chk("rst third write", 32'(cnt), 32'd3);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst ready", 32'(rq.o_req_ready), 32'd1);
    chk("rst dmem en", {30'h0, dm.o_dmem_rd_en, dm.o_dmem_wr_en}, 0);
    chk("rst dmem addr", dm.o_dmem_addr, 32'h0);
    chk("rst dmem wdata", dm.o_dmem_wdata, 32'h0);
    if (rq.o_rsp_valid) rs = 1;
    repeat (4) begin
      @(negedge clk);
      if (rq.o_rsp_valid) rs = 1;
    end
    chk("rst no rsp", 32'(rs), 32'd0);
    chk("rst mem", {mb(32'h606), mb(32'h605), mb(32'h604), mb(32'h603)},
        32'h4433F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Core-side load/store unit and the initiator for the data-memory port of main memory.
- Accepts one load or store request at a time from the execute/memory stage using a valid/ready handshake.
- Sequences the accesses on the dmem port (rd_en/wr_en, rd_type/wr_type, addr, wdata). Splits misaligned accesses into multiple aligned accesses.
- Returns one response per request, carrying load data or an error flag.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split misaligned lh/lhu/lw/sh/sw into legal accesses; 0 = reject them with rsp_err.
- TAG_W, 5: width of the destination-register tag carried through with a request.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  request present
- o_req_ready  out  1  high only in IDLE
- i_req_we  in  1  1 = store, 0 = load
- i_req_funct3  in  3  RISC-V funct3. Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Stores: 000 sb, 001 sh, 010 sw.
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-aligned
- i_req_tag  in  TAG_W  rd tag, returned unchanged
- o_rsp_valid  out  1  one-cycle completion pulse; no backpressure
- o_rsp_rdata  out  32  load result, already extended; 0 for stores and errors
- o_rsp_tag  out  TAG_W  tag of the completed request
- o_rsp_err  out  1  illegal funct3, or misaligned access with SPLIT_MISALIGNED=0
- o_dmem_addr  out  32  memory byte address
- o_dmem_wdata  out  32  memory write data
- o_dmem_wr_type  out  2  01 sb, 10 sh, 11 sw
- o_dmem_rd_type  out  3  always 000 (word read)
- o_dmem_wr_en  out  1  write strobe; memory writes on the clk edge ending the cycle
- o_dmem_rd_en  out  1  read strobe
- i_dmem_rdata  in  32  memory read data, combinational from o_dmem_addr

Behaviour:
- Reset: state IDLE; all outputs 0 except o_req_ready = 1. Reset in any state aborts the operation with no response. Bytes of a split store already written stay written.
- Handshake: request accepted when i_req_valid && o_req_ready at a clock edge; all request fields are captured at that edge.
- dmem outputs are registered. rd_en and wr_en are never high together. Between accesses addr, wdata and types are 0.
- Loads always read full words (rd_type 000). Lane select and sign/zero extension are done here: memory lb/lh extension is not used.
- Aligned access: addr[0]=0 for halfwords, addr[1:0]=0 for words; bytes are always aligned.
- States: IDLE, LD0, LD1, ST, RESP.
- Aligned load (accept at edge T):
  - LD0 in cycle T+1, addr = A & ~3, rd_en = 1; the read word is latched at the end of the cycle.
  - RESP in cycle T+2 with o_rsp_valid = 1.
- Misaligned load (split enabled):
  - LD0 reads A & ~3; LD1 in cycle T+2 reads (A & ~3) + 4, mod 2^32.
  - Result = bytes of {w1, w0} >> (8 * A[1:0]), then extended.
  - RESP in cycle T+3.
- Aligned store:
  - ST for one cycle: addr = A, wdata = the store data replicated into the target lane(s), wr_type per funct3, wr_en = 1.
  - RESP in the next cycle.
- Misaligned sh/sw (split enabled):
  - ST issues N sb writes on consecutive cycles (N = 2 or 4); write i uses addr A + i and byte i of wdata.
  - A 2-bit byte counter runs from 0 to N-1; RESP follows the last write.
  - Latency: sh T+3, sw T+5.
- Error cases: illegal funct3, or misaligned access with split disabled.
  - No dmem access.
  - RESP at T+1 with err = 1 and rdata = 0.
- RESP lasts one cycle, then IDLE; ready rises in the same cycle RESP is left. Back-to-back throughput for aligned loads: one request per 3 cycles.
- o_rsp_rdata, o_rsp_tag and o_rsp_err are valid only while o_rsp_valid is high, and are 0 otherwise.
- Address arithmetic is 32-bit and wraps: 0xFFFFFFFF + 1 = 0x00000000.

Decomposition:
- Shared defines header holds:
  - funct3 load/store encodings;
  - dmem wr_type encodings (SB = 2'b01, SH = 2'b10, SW = 2'b11);
  - RD_WORD = 3'b000;
  - state encodings.
- One combinational sub-module, lsu_load_align: inputs {w1, w0}, offset and funct3; output is the extended 32-bit result. It is reused for the aligned case with w1 = 0.

Test Plan:
- mem[0x100] = 0x8899AABB; lb at 0x101 tag 7 -> rsp at T+2 with rdata 0xFFFFFFAA and tag 7; lbu at 0x101 -> 0x000000AA.
- mem[0x100] = 0x44332211, mem[0x104] = 0x88776655; lw at 0x102 -> rd_en on two cycles (addr 0x100 then 0x104); rdata 0x66554433 at T+3.
- sw 0xDEADBEEF at 0x203 -> four sb writes at 0x203..0x206 with wdata low bytes EF, BE, AD, DE; mem[0x200] byte 3 = 0xEF; mem[0x204][23:0] = 0xDEADBE; rsp at T+5.
- sh 0x1234 at 0x302 -> single write: wr_type 10, addr 0x302, wdata 0x12341234; rsp at T+2.
- SPLIT_MISALIGNED=0, lw at 0x401 -> no rd_en or wr_en; rsp at T+1 with err = 1, rdata 0. Load funct3 = 011 -> same response.
- rst asserted during the third sb of a misaligned sw -> no rsp; outputs 0 and ready = 1 on the next cycle; first two bytes written, last two untouched.
